mem_access_unit: RTL and testbench

Initiator-side memory port controller for the 16-bit multicycle core. It accepts instruction-fetch and load/store requests from the datapath through req/ack handshakes and arbitrates between them. It drives the single-port data memory: combinational read, write on the rising clock edge, byte address with word index taken from address bits [15:1]. It also checks alignment and range, and returns read data in registers.

---
 rtl/mem_access_unit.sv | 120 ++++++++++++
 tb/tb_mem_access_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory port controller: arbitrates fetch and load/store requests
// onto a single-port data memory with alignment and range checking.
module mem_access_unit #(
  parameter int AW        = 16,
  parameter int DW        = 16,
  parameter int MEM_WORDS = 128
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_instr,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  output logic          ls_ack,
  output logic [DW-1:0] ls_rdata,
  output logic          acc_err,
  output logic          busy,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rd
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t state, nxt;

  logic          grant;
  logic          sel_ls;
  logic [AW-1:0] g_addr;
  logic          g_err;

  logic src_ls;
  logic cap_we;
  logic cap_err;
  logic last_ls;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // Round-robin: under contention, the class not served last wins.
  always_comb begin
    nxt    = state;
    grant  = 1'b0;
    sel_ls = 1'b0;
    unique case (state)
      IDLE: begin
        if (if_req || ls_req) begin
          grant  = 1'b1;
          sel_ls = ls_req && (!if_req || !last_ls);
          nxt    = ACCESS;
        end
      end
      ACCESS:  nxt = RESP;
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign g_addr = sel_ls ? ls_addr : if_addr;
  assign g_err  = g_addr[0] |
                  ({1'b0, g_addr[AW-1:1]} >= AW'(MEM_WORDS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_ls   <= 1'b0;
      cap_we   <= 1'b0;
      cap_err  <= 1'b0;
      last_ls  <= 1'b0;
      mem_a    <= '0;
      mem_wd   <= '0;
      mem_we   <= 1'b0;
      if_ack   <= 1'b0;
      ls_ack   <= 1'b0;
      acc_err  <= 1'b0;
      busy     <= 1'b0;
      if_instr <= '0;
      ls_rdata <= '0;
    end else begin
      busy    <= (nxt != IDLE);
      mem_we  <= 1'b0;
      if_ack  <= 1'b0;
      ls_ack  <= 1'b0;
      acc_err <= 1'b0;
      if (grant) begin
        src_ls  <= sel_ls;
        cap_we  <= sel_ls & ls_we;
        cap_err <= g_err;
        last_ls <= sel_ls;
        mem_a   <= g_addr;
        mem_wd  <= ls_wdata;
        mem_we  <= sel_ls & ls_we & ~g_err;
      end
      if (state == ACCESS) begin
        if_ack  <= ~src_ls;
        ls_ack  <= src_ls;
        acc_err <= cap_err;
        // Suppressed accesses return zero, stores included.
        if (cap_err) begin
          if (src_ls) ls_rdata <= '0;
          else        if_instr <= '0;
        end else if (!cap_we) begin
          if (src_ls) ls_rdata <= mem_rd;
          else        if_instr <= mem_rd;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural
// 128-word memory model.
module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_ack;
  logic [15:0] if_instr;
  logic        ls_req;
  logic        ls_we;
  logic [15:0] ls_addr;
  logic [15:0] ls_wdata;
  logic        ls_ack;
  logic [15:0] ls_rdata;
  logic        acc_err;
  logic        busy;
  logic [15:0] mem_a;
  logic [15:0] mem_wd;
  logic        mem_we;
  logic [15:0] mem_rd;

  logic [15:0] mem [0:127];

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int lsack_cnt = 0;

  logic        a_busy, a_we, a_ack;
  logic [15:0] a_a, a_wd;
  logic        r_if, r_ls, r_err, r_we, r_busy;
  logic [15:0] r_instr, r_rdata;
  logic        i_busy, i_ack;
  int          we_d;

  mem_access_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_ack   (if_ack),
    .if_instr (if_instr),
    .ls_req   (ls_req),
    .ls_we    (ls_we),
    .ls_addr  (ls_addr),
    .ls_wdata (ls_wdata),
    .ls_ack   (ls_ack),
    .ls_rdata (ls_rdata),
    .acc_err  (acc_err),
    .busy     (busy),
    .mem_a    (mem_a),
    .mem_wd   (mem_wd),
    .mem_we   (mem_we),
    .mem_rd   (mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rd = (mem_a[15:8] == 8'h00) ? mem[mem_a[7:1]] : 16'h0000;

  always @(posedge clk)
    if (mem_we && mem_a[15:8] == 8'h00) mem[mem_a[7:1]] <= mem_wd;

  always @(negedge clk) begin
    if (mem_we) we_cnt = we_cnt + 1;
    if (ls_ack) lsack_cnt = lsack_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic check_rst(input string tag);
    check({tag, "_ctl"},
          {27'd0, mem_we, if_ack, ls_ack, acc_err, busy}, 32'd0);
    check({tag, "_ma"}, {mem_wd, mem_a}, 32'd0);
    check({tag, "_rd"}, {if_instr, ls_rdata}, 32'd0);
  endtask

  // One full transaction from an IDLE cycle: grant, ACCESS, RESP, IDLE.
  task automatic txn(input logic ls, input logic we,
                     input logic [15:0] a, input logic [15:0] wd);
    int w0;
    if (ls) begin
      ls_req = 1'b1; ls_we = we; ls_addr = a; ls_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = a;
    end
    w0 = we_cnt;
    @(posedge clk); #1;
    a_busy = busy; a_a = mem_a; a_wd = mem_wd;
    a_we = mem_we; a_ack = if_ack | ls_ack;
    @(posedge clk); #1;
    r_if = if_ack; r_ls = ls_ack; r_err = acc_err;
    r_instr = if_instr; r_rdata = ls_rdata;
    r_we = mem_we; r_busy = busy;
    if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
    @(posedge clk); #1;
    i_busy = busy; i_ack = if_ack | ls_ack;
    we_d = we_cnt - w0;
  endtask

  initial begin
    int n;
    int acyc [4];
    logic als [4];

    for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
    mem[0]    = 16'hF010;
    mem[1]    = 16'hABCD;
    mem[8]    = 16'h7777;
    mem[8'h42] = 16'h5A5A;

    rst_n = 1'b0; if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
    #12;
    check_rst("reset");
    @(negedge clk); rst_n = 1'b1;

    // Fetch
    txn(1'b0, 1'b0, 16'h0000, 16'h0000);
    check("f_acc", {29'd0, a_busy, a_we, a_ack}, {29'd0, 3'b100});
    check("f_mema", a_a, 16'h0000);
    check("f_ack", {30'd0, r_if, r_ls}, 32'd2);
    check("f_instr", r_instr, 16'hF010);
    check("f_err", r_err, 1'b0);
    check("f_idle", {30'd0, i_busy, i_ack}, 32'd0);

    // Store then load
    txn(1'b1, 1'b1, 16'h0084, 16'h1234);
    check("st_we", a_we, 1'b1);
    check("st_a", a_a, 16'h0084);
    check("st_wd", a_wd, 16'h1234);
    check("st_pulse", we_d, 1);
    check("st_ack", {29'd0, r_if, r_ls, r_err}, 32'b010);
    check("st_mem", mem[8'h42], 16'h1234);
    txn(1'b1, 1'b0, 16'h0084, 16'h0000);
    check("ld_ack", {29'd0, r_if, r_ls, r_err}, 32'b010);
    check("ld_data", r_rdata, 16'h1234);
    check("ld_nowe", we_d, 0);

    // Misaligned store
    txn(1'b1, 1'b1, 16'h0085, 16'hBEEF);
    check("mis_nowe", we_d, 0);
    check("mis_ack", {29'd0, r_if, r_ls, r_err}, 32'b011);
    check("mis_rdata", r_rdata, 16'h0000);
    check("mis_mem", mem[8'h42], 16'h1234);

    // Out-of-range fetch
    txn(1'b0, 1'b0, 16'h0100, 16'h0000);
    check("oor_ack", {29'd0, r_if, r_ls, r_err}, 32'b101);
    check("oor_instr", r_instr, 16'h0000);

    // Boundary: last legal word
    mem[127] = 16'h4321;
    txn(1'b0, 1'b0, 16'h00FE, 16'h0000);
    check("top_ok", {29'd0, r_if, r_ls, r_err}, 32'b100);
    check("top_instr", r_instr, 16'h4321);

    // Contention from a fresh reset
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    if_req = 1'b1; if_addr = 16'h0002;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h0084;
    n = 0;
    for (int c = 1; c <= 20 && n < 4; c++) begin
      @(posedge clk); #1;
      if (if_ack || ls_ack) begin
        acyc[n] = c;
        als[n] = ls_ack;
        if (ls_ack) check("arb_ldata", ls_rdata, 16'h1234);
        else        check("arb_idata", if_instr, 16'hABCD);
        n++;
      end
    end
    check("arb_count", n, 4);
    if_req = 1'b0; ls_req = 1'b0;
    for (int k = 0; k < n; k++) begin
      check($sformatf("arb_src%0d", k), als[k], (k % 2 == 0));
      check($sformatf("arb_cyc%0d", k), acyc[k], 2 + 3 * k);
    end
    repeat (3) @(posedge clk);
    #1;

    // Reset during a store's ACCESS cycle
    lsack_cnt = 0;
    ls_req = 1'b1; ls_we = 1'b1;
    ls_addr = 16'h0010; ls_wdata = 16'hDEAD;
    @(posedge clk); #1;
    check("rm_we_pre", mem_we, 1'b1);
    #2;
    rst_n = 1'b0;
    ls_req = 1'b0; ls_we = 1'b0;
    #1;
    check("rm_we_drop", mem_we, 1'b0);
    @(posedge clk); #1;
    check("rm_mem", mem[8], 16'h7777);
    @(negedge clk); rst_n = 1'b1;
    #1;
    check_rst("rm_post");
    repeat (4) @(posedge clk);
    #1;
    check("rm_noack", lsack_cnt, 0);
    check("rm_idle", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
